cordic_phase_gen: RTL and testbench

CORDIC_PHASE_GEN -- requirements
Module: cordic_phase_gen

---
 rtl/cordic_phase_pkg.sv | 16 +
 rtl/cordic_lfsr.sv | 29 ++
 rtl/cordic_phase_gen.sv | 176 +++++++++++++++++
 tb/tb_cordic_phase_gen.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_phase_pkg.sv
// Shared types and constants for the cordic phase generator.
// FSM state encoding, dither LFSR seed/taps and burst counter width.
package cordic_phase_pkg;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_e;

  // Fibonacci LFSR, taps 16,14,13,11 as a right-shift mask on bits 0,2,3,5
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  localparam int BURST_W = 16;

endpackage

// File: rtl/cordic_lfsr.sv
// 16-bit Fibonacci LFSR used to dither the truncated phase.
// Ports: clk, rst_n (async low), adv (step once), lfsr (current state).
module cordic_lfsr
  import cordic_phase_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        adv,
  output logic [15:0] lfsr
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (adv) begin
      lfsr_d = {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/cordic_phase_gen.sv
// Phase accumulator feeding a cordic stage: bursts of st/phi samples
// every cfgDiv+1 clocks. Ports: clk, reset (async low), cfg* shadow
// writes (cfgWe), start/stop/burstLen control, st/phi/busy/done out.
// Optional phase dither enabled by CORDIC_PHASE_DITHER_EN.
module cordic_phase_gen
  import cordic_phase_pkg::*;
#(
  parameter int PHI_WIDTH = 16,
  parameter int ACC_WIDTH = 24,
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfgWe,
  input  logic [ACC_WIDTH-1:0] cfgFreq,
  input  logic [PHI_WIDTH-1:0] cfgPhase,
  input  logic [DIV_WIDTH-1:0] cfgDiv,
  input  logic                 start,
  input  logic                 stop,
  input  logic [BURST_W-1:0]   burstLen,
  output logic                 st,
  output logic [PHI_WIDTH-1:0] phi,
  output logic                 busy,
  output logic                 done
);

  state_e               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [BURST_W-1:0]   cnt_q, cnt_d;
  logic [BURST_W-1:0]   burst_q, burst_d;
  logic [ACC_WIDTH-1:0] sh_freq_q, sh_freq_d;
  logic [PHI_WIDTH-1:0] sh_phase_q, sh_phase_d;
  logic [DIV_WIDTH-1:0] sh_div_q, sh_div_d;
  logic [ACC_WIDTH-1:0] act_freq_q, act_freq_d;
  logic [PHI_WIDTH-1:0] act_phase_q, act_phase_d;
  logic [DIV_WIDTH-1:0] act_div_q, act_div_d;
  logic                 st_q, st_d;
  logic                 done_q, done_d;
  logic [PHI_WIDTH-1:0] phi_q, phi_d;

  logic                 tick;
  logic [BURST_W-1:0]   cnt_inc;
  logic [PHI_WIDTH-1:0] acc_top;

  // stop wins over a tick due in the same cycle
  assign tick    = (state_q == S_RUN) && (div_q == '0) && !stop;
  assign cnt_inc = cnt_q + BURST_W'(1);

`ifdef CORDIC_PHASE_DITHER_EN
  localparam int DITH_W = ACC_WIDTH - PHI_WIDTH;

  logic [15:0]          lfsr;
  logic [ACC_WIDTH-1:0] dith;
  logic [ACC_WIDTH-1:0] acc_mix;

  cordic_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (reset),
    .adv   (tick),
    .lfsr  (lfsr)
  );

  always_comb begin
    dith = '0;
    for (int i = 0; i < DITH_W; i++) begin
      dith[i] = lfsr[i];
    end
  end

  // dither only shapes the output; acc itself stays exact
  assign acc_mix = acc_q + dith;
  assign acc_top = acc_mix[ACC_WIDTH-1 -: PHI_WIDTH];
`else
  assign acc_top = acc_q[ACC_WIDTH-1 -: PHI_WIDTH];
`endif

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    div_d       = div_q;
    cnt_d       = cnt_q;
    burst_d     = burst_q;
    act_freq_d  = act_freq_q;
    act_phase_d = act_phase_q;
    act_div_d   = act_div_q;
    sh_freq_d   = sh_freq_q;
    sh_phase_d  = sh_phase_q;
    sh_div_d    = sh_div_q;
    st_d        = 1'b0;
    done_d      = 1'b0;
    phi_d       = phi_q;

    if (cfgWe) begin
      sh_freq_d  = cfgFreq;
      sh_phase_d = cfgPhase;
      sh_div_d   = cfgDiv;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d     = S_RUN;
          acc_d       = '0;
          cnt_d       = '0;
          burst_d     = burstLen;
          div_d       = '0;
          act_freq_d  = sh_freq_q;
          act_phase_d = sh_phase_q;
          act_div_d   = sh_div_q;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (tick) begin
          st_d        = 1'b1;
          phi_d       = acc_top + act_phase_q;
          acc_d       = acc_q + act_freq_q;
          div_d       = act_div_q;
          act_freq_d  = sh_freq_q;
          act_phase_d = sh_phase_q;
          act_div_d   = sh_div_q;
          cnt_d       = cnt_inc;
          if ((burst_q != '0) && (cnt_inc == burst_q)) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          div_d = div_q - DIV_WIDTH'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      div_q       <= '0;
      cnt_q       <= '0;
      burst_q     <= '0;
      sh_freq_q   <= '0;
      sh_phase_q  <= '0;
      sh_div_q    <= '0;
      act_freq_q  <= '0;
      act_phase_q <= '0;
      act_div_q   <= '0;
      st_q        <= 1'b0;
      done_q      <= 1'b0;
      phi_q       <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      burst_q     <= burst_d;
      sh_freq_q   <= sh_freq_d;
      sh_phase_q  <= sh_phase_d;
      sh_div_q    <= sh_div_d;
      act_freq_q  <= act_freq_d;
      act_phase_q <= act_phase_d;
      act_div_q   <= act_div_d;
      st_q        <= st_d;
      done_q      <= done_d;
      phi_q       <= phi_d;
    end
  end

  assign st   = st_q;
  assign phi  = phi_q;
  assign done = done_q;
  assign busy = (state_q == S_RUN);

endmodule

// File: tb/tb_cordic_phase_gen.sv
// Self-checking bench for cordic_phase_gen: per-cycle expected-output
// tables built from sample arithmetic, plus literal phi/timing checks.
module tb_cordic_phase_gen;

  localparam int PW = 16;
  localparam int AW = 24;
  localparam int DW = 8;
  localparam int NC = 1024;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cfgWe = 1'b0;
  logic [AW-1:0] cfgFreq = '0;
  logic [PW-1:0] cfgPhase = '0;
  logic [DW-1:0] cfgDiv = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [15:0]   burstLen = '0;
  logic          st;
  logic [PW-1:0] phi;
  logic          busy;
  logic          done;

  cordic_phase_gen #(
    .PHI_WIDTH(PW),
    .ACC_WIDTH(AW),
    .DIV_WIDTH(DW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cfgWe    (cfgWe),
    .cfgFreq  (cfgFreq),
    .cfgPhase (cfgPhase),
    .cfgDiv   (cfgDiv),
    .start    (start),
    .stop     (stop),
    .burstLen (burstLen),
    .st       (st),
    .phi      (phi),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          errs = 0;
  int          checks = 0;
  bit          e_st[NC];
  bit          e_done[NC];
  bit          e_busy[NC];
  logic [15:0] e_phi[NC];
  int          st_cyc[$];
  logic [15:0] st_phi[$];
  logic [15:0] lfsr_m = 16'hACE1;

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  initial begin
    for (int i = 0; i < NC; i++) begin
      e_st[i] = 0; e_done[i] = 0; e_busy[i] = 0; e_phi[i] = '0;
    end
  end

  // cycle index c = the clock period following the c-th rising edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc < NC) begin
        chk("st", st, e_st[cyc]);
        chk("done", done, e_done[cyc]);
        chk("busy", busy, e_busy[cyc]);
        chk("phi", phi, e_phi[cyc]);
        if (st) begin
          st_cyc.push_back(cyc);
          st_phi.push_back(phi);
        end
      end
    end
  end

  // expected outputs of a burst accepted at edge e: sample k appears in
  // period e+1+k*(div+1) with phi = top bits of k*freq plus the offset
  task automatic fill(int e, longint f, longint ph, int dv, int n,
                      bit dn, int bend);
    longint acc;
    longint a;
    longint p;
    int     c;
    acc = 0;
    c = e;
    for (int k = 0; k < n; k++) begin
      c = e + 1 + k * (dv + 1);
      a = acc;
`ifdef CORDIC_PHASE_DITHER_EN
      a = (a + longint'(lfsr_m & 16'h00FF)) % (longint'(1) << AW);
`endif
      p = ((a >> (AW - PW)) + ph) % (longint'(1) << PW);
      e_st[c] = 1;
      for (int j = c; j < NC; j++) e_phi[j] = 16'(p);
      acc = (acc + f) % (longint'(1) << AW);
      lfsr_m = {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5],
                lfsr_m[15:1]};
    end
    if (dn) e_done[c] = 1;
    if (bend < 0) bend = c - 1;
    for (int j = e; j <= bend; j++) e_busy[j] = 1;
  endtask

  task automatic clear_from(int c);
    for (int j = c; j < NC; j++) begin
      e_st[j] = 0; e_done[j] = 0; e_busy[j] = 0; e_phi[j] = '0;
    end
  endtask

  task automatic wait_cyc(int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic cfg(logic [AW-1:0] f, logic [PW-1:0] p,
                     logic [DW-1:0] d);
    @(negedge clk);
    cfgWe = 1'b1; cfgFreq = f; cfgPhase = p; cfgDiv = d;
    @(negedge clk);
    cfgWe = 1'b0; cfgFreq = '0; cfgPhase = '0; cfgDiv = '0;
  endtask

  task automatic go(longint f, longint ph, int dv, int len, int n,
                    bit dn, int brel, output int e);
    @(negedge clk);
    e = cyc + 1;
    fill(e, f, ph, dv, n, dn, (brel < 0) ? -1 : e + brel);
    st_cyc.delete();
    st_phi.delete();
    burstLen = 16'(len);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  int          e;
  logic [15:0] exp4[4] = '{16'h0000, 16'h0100, 16'h0200, 16'h0300};
  logic [15:0] exp5[5] = '{16'h0000, 16'h4000, 16'h8000, 16'hC000,
                           16'h0000};
  logic [15:0] exp3[3] = '{16'hF000, 16'h1000, 16'h3000};

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_st", st, 0);
    chk("rst_phi", phi, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b1;

    // div=0, four back-to-back samples
    cfg(24'h010000, 16'h0000, 8'd0);
    go(24'h010000, 0, 0, 4, 4, 1, -1, e);
    wait_cyc(e + 8);
    chk("t1_count", st_cyc.size(), 4);
    for (int i = 0; i < 4 && i < st_phi.size(); i++)
      chk("t1_phi", st_phi[i], exp4[i]);
    chk("t1_busy_after", busy, 0);

    // div=3: spacing of 4, plus a start pulse mid-run that is ignored
    cfg(24'h010000, 16'h0000, 8'd3);
    go(24'h010000, 0, 3, 3, 3, 1, -1, e);
    wait_cyc(e + 2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cyc(e + 14);
    chk("t2_count", st_cyc.size(), 3);
    if (st_cyc.size() == 3) begin
      chk("t2_first", st_cyc[0], e + 1);
      chk("t2_gap1", st_cyc[1] - st_cyc[0], 4);
      chk("t2_gap2", st_cyc[2] - st_cyc[1], 4);
    end

    // accumulator wrap
    cfg(24'h400000, 16'h0000, 8'd0);
    go(24'h400000, 0, 0, 5, 5, 1, -1, e);
    wait_cyc(e + 9);
    chk("t3_count", st_cyc.size(), 5);
    for (int i = 0; i < 5 && i < st_phi.size(); i++)
      chk("t3_phi", st_phi[i], exp5[i]);

    // phase offset wrap
    cfg(24'h200000, 16'hF000, 8'd0);
    go(24'h200000, 16'hF000, 0, 3, 3, 1, -1, e);
    wait_cyc(e + 7);
    chk("t4_count", st_cyc.size(), 3);
    for (int i = 0; i < 3 && i < st_phi.size(); i++)
      chk("t4_phi", st_phi[i], exp3[i]);

    // start together with stop in IDLE stays idle
    @(negedge clk);
    burstLen = 16'd2;
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_busy", busy, 0);

    // continuous, div=2, stop lands on the third tick period
    cfg(24'h010000, 16'h0000, 8'd2);
    go(24'h010000, 0, 2, 0, 2, 0, 6, e);
    wait_cyc(e + 6);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_cyc(e + 10);
    chk("t6_count", st_cyc.size(), 2);
    chk("t6_busy", busy, 0);

`ifdef CORDIC_PHASE_DITHER_EN
    cfg(24'h000080, 16'h0000, 8'd0);
    go(24'h000080, 0, 0, 64, 64, 1, -1, e);
    wait_cyc(e + 68);
    chk("t7_count", st_cyc.size(), 64);
    for (int i = 0; i < 64 && i < st_phi.size(); i++)
      chk("t7_dither_lsb", (st_phi[i] - 16'(i / 2)) <= 16'd1, 1);
`endif

    // reset mid-run clears outputs at once
    cfg(24'h010000, 16'h0000, 8'd0);
    go(24'h010000, 0, 0, 0, 5, 0, 5, e);
    wait_cyc(e + 5);
    clear_from(e + 6);
    reset = 1'b0;
    #1;
    chk("t8_st", st, 0);
    chk("t8_phi", phi, 0);
    chk("t8_busy", busy, 0);
    chk("t8_done", done, 0);
    lfsr_m = 16'hACE1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    wait_cyc(cyc + 5);
    chk("t8_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
